// File: rtl/fp_acc_pkg.sv
// Shared types and constants for the floating-point frame accumulator controller.
package fp_acc_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_ADD   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam int FP_W     = 32;
    localparam int SIGN_BIT = 31;
    localparam int CNT_W    = 16;

    // Bit positions inside the sticky flag vector {exception, overflow, underflow}
    localparam int FLG_EXC = 2;
    localparam int FLG_OVF = 1;
    localparam int FLG_UNF = 0;

endpackage

// File: rtl/fp_accum_ctrl.sv
// Sequences a frame of single-precision elements through an external adder,
// keeping the running sum, element count and sticky adder flags per frame.
module fp_accum_ctrl
    import fp_acc_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [FP_W-1:0]  in_data,
    input  logic             in_sub,
    input  logic             in_last,
    output logic [FP_W-1:0]  add_a,
    output logic [FP_W-1:0]  add_b,
    input  logic [FP_W-1:0]  add_res,
    input  logic             add_underflow,
    input  logic             add_overflow,
    input  logic             add_exception,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [FP_W-1:0]  out_sum,
    output logic [CNT_W-1:0] out_count,
    output logic [2:0]       out_flags,
    output state_t           dbg_state
);

    // Handshakes: an element moves when in_valid & in_ready on a rising edge;
    // a result moves when out_valid & out_ready. Neither side may retract
    // valid before the transfer, and ready never depends on the peer's valid.

    state_t            state;
    state_t            state_nxt;
    logic [FP_W-1:0]   acc;
    logic [FP_W-1:0]   opb;
    logic [FP_W-1:0]   operand;
    logic [CNT_W-1:0]  count;
    logic [2:0]        flags;
    logic [2:0]        add_flags;
    logic              last_q;
    logic              accept;

    assign operand = {in_data[SIGN_BIT] ^ in_sub, in_data[SIGN_BIT-1:0]};
    assign accept  = in_valid & in_ready;

    always_comb begin
        add_flags          = '0;
        add_flags[FLG_EXC] = add_exception;
        add_flags[FLG_OVF] = add_overflow;
        add_flags[FLG_UNF] = add_underflow;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept) state_nxt = in_last ? S_DONE : S_ACCUM;
            S_ACCUM: if (accept) state_nxt = S_ADD;
            S_ADD:   state_nxt = last_q ? S_DONE : S_ACCUM;
            S_DONE:  if (out_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = !rst && ((state == S_IDLE) || (state == S_ACCUM));
        out_valid = (state == S_DONE);
        dbg_state = state;
    end

    // The first element bypasses the adder because it mishandles a zero operand.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc    <= '0;
            opb    <= '0;
            count  <= '0;
            flags  <= '0;
            last_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (accept) begin
                    acc   <= operand;
                    count <= {{(CNT_W-1){1'b0}}, 1'b1};
                    flags <= '0;
                end
                S_ACCUM: if (accept) begin
                    opb    <= operand;
                    count  <= (count == {CNT_W{1'b1}}) ? count : count + 1'b1;
                    last_q <= in_last;
                end
                S_ADD: begin
                    acc   <= add_res;
                    flags <= flags | add_flags;
                end
                default: ;
            endcase
        end
    end

    assign add_a     = acc;
    assign add_b     = opb;
    assign out_sum   = acc;
    assign out_count = count;
    assign out_flags = flags;

endmodule

// File: tb/tb_fp_accum_ctrl.sv
// Self-checking bench for fp_accum_ctrl with a real-arithmetic adder and frame model.
module tb_fp_accum_ctrl;
    import fp_acc_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, in_sub, in_last;
    logic [31:0] in_data;
    logic [31:0] add_a, add_b, add_res;
    logic        add_underflow, add_overflow, add_exception;
    logic        out_valid, out_ready;
    logic [31:0] out_sum;
    logic [15:0] out_count;
    logic [2:0]  out_flags;
    state_t      dbg_state;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    logic [31:0] exp_q[$];

    fp_accum_ctrl dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_sub(in_sub), .in_last(in_last),
        .add_a(add_a), .add_b(add_b), .add_res(add_res),
        .add_underflow(add_underflow), .add_overflow(add_overflow),
        .add_exception(add_exception), .out_valid(out_valid),
        .out_ready(out_ready), .out_sum(out_sum), .out_count(out_count),
        .out_flags(out_flags), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- float helpers (normal numbers only) ----------------
    function automatic real f2r(input logic [31:0] b);
        real v;
        int  e;
        if (b[30:0] == 31'd0) return 0.0;
        v = 1.0 + real'(b[22:0]) / 8388608.0;
        e = int'(b[30:23]) - 127;
        while (e > 0) begin v = v * 2.0; e--; end
        while (e < 0) begin v = v / 2.0; e++; end
        return b[31] ? -v : v;
    endfunction

    function automatic logic [31:0] r2f(input real v);
        logic        s;
        real         a;
        int          e;
        int          mi;
        logic [7:0]  eb;
        logic [22:0] m;
        if (v == 0.0) return 32'h0;
        s = (v < 0.0);
        a = s ? -v : v;
        e = 127;
        while (a >= 2.0) begin a = a / 2.0; e++; end
        while (a < 1.0)  begin a = a * 2.0; e--; end
        mi = $rtoi((a - 1.0) * 8388608.0 + 0.5);
        eb = e[7:0];
        m  = mi[22:0];
        return {s, eb, m};
    endfunction

    // External adder stand-in
    always_comb add_res = r2f(f2r(add_a) + f2r(add_b));

    // ---------------- driver tasks ----------------
    task automatic send(input logic [31:0] d, input logic s, input logic l,
                        input logic first, input logic [2:0] flg, output int acc_cyc);
        int n;
        n = 0;
        in_data = d; in_sub = s; in_last = l; in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 20) begin @(negedge clk); n++; end
        if (!in_ready) begin
            n_cmp++; n_err++;
            $display("FAIL send_timeout: in_ready=%0b required 1", in_ready);
        end
        acc_cyc = cyc;
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (!first) begin
            {add_exception, add_overflow, add_underflow} = flg;
            @(posedge clk); #1;
            {add_exception, add_overflow, add_underflow} = 3'b000;
        end
    endtask

    task automatic wait_result(output int v_cyc);
        int n;
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 30) begin @(negedge clk); n++; end
        if (!out_valid) begin
            n_cmp++; n_err++;
            $display("FAIL result_timeout: out_valid=%0b required 1", out_valid);
        end
        v_cyc = cyc;
    endtask

    task automatic take();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        @(negedge clk);
        n_cmp++;
        if ({out_valid, in_ready, out_sum, out_count, out_flags, add_a, add_b} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: valid=%0b ready=%0b sum=%h cnt=%h flg=%b a=%h b=%h required all 0",
                     out_valid, in_ready, out_sum, out_count, out_flags, add_a, add_b);
        end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++; $display("FAIL reset_ready: got %0b required 1", in_ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_two_elem();
        int c0, c1, cv;
        send(32'h3F800000, 1'b0, 1'b0, 1'b1, 3'b000, c0);
        send(32'h40000000, 1'b0, 1'b1, 1'b0, 3'b000, c1);
        wait_result(cv);
        n_cmp++;
        if ({out_sum, out_count, out_flags} !== {32'h40400000, 16'd2, 3'b000}) begin
            n_err++;
            $display("FAIL two_elem_result: got %h/%0d/%b required 40400000/2/000", out_sum, out_count, out_flags);
        end
        n_cmp++;
        if (cv - c0 !== 3) begin
            n_err++; $display("FAIL two_elem_latency: got %0d required 3", cv - c0);
        end
        n_cmp++;
        if (c1 - c0 !== 1) begin
            n_err++; $display("FAIL two_elem_second_accept: got %0d required 1", c1 - c0);
        end
        take();
    endtask

    task automatic test_single_sub();
        int c0, cv;
        logic [31:0] b0;
        b0 = add_b;
        send(32'h3FC00000, 1'b1, 1'b1, 1'b1, 3'b000, c0);
        wait_result(cv);
        n_cmp++;
        if ({out_sum, out_count, out_flags} !== {32'hBFC00000, 16'd1, 3'b000}) begin
            n_err++;
            $display("FAIL single_sub_result: got %h/%0d/%b required BFC00000/1/000", out_sum, out_count, out_flags);
        end
        n_cmp++;
        if (cv - c0 !== 1) begin
            n_err++; $display("FAIL single_latency: got %0d required 1", cv - c0);
        end
        n_cmp++;
        if (add_b !== b0) begin
            n_err++; $display("FAIL single_add_b: got %h required %h", add_b, b0);
        end
        take();
    endtask

    task automatic test_subtract();
        int c, cv;
        send(32'h40400000, 1'b0, 1'b0, 1'b1, 3'b000, c);
        send(32'h3F800000, 1'b1, 1'b1, 1'b0, 3'b000, c);
        wait_result(cv);
        n_cmp++;
        if ({out_sum, out_count} !== {32'h40000000, 16'd2}) begin
            n_err++; $display("FAIL subtract_result: got %h/%0d required 40000000/2", out_sum, out_count);
        end
        take();
    endtask

    task automatic test_hold_and_same_cycle();
        int c, cv;
        send(32'h40A00000, 1'b0, 1'b1, 1'b1, 3'b000, c);
        wait_result(cv);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            in_valid = (i % 2 == 0);
            in_data  = $urandom; in_sub = 1'b0; in_last = 1'b1;
            @(negedge clk);
            n_cmp++;
            if ({out_valid, in_ready, out_sum, out_count} !== {1'b1, 1'b0, 32'h40A00000, 16'd1}) begin
                n_err++;
                $display("FAIL hold_cycle%0d: valid=%0b ready=%0b sum=%h cnt=%0d required 1/0/40A00000/1",
                         i, out_valid, in_ready, out_sum, out_count);
            end
        end
        @(posedge clk); #1;
        in_data = 32'h3F800000; in_sub = 1'b0; in_last = 1'b1; in_valid = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_err++; $display("FAIL same_cycle_idle: valid=%0b ready=%0b required 0/1", out_valid, in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({out_valid, out_sum, out_count, out_flags} !== {1'b1, 32'h3F800000, 16'd1, 3'b000}) begin
            n_err++;
            $display("FAIL same_cycle_result: valid=%0b sum=%h cnt=%0d flg=%b required 1/3F800000/1/000",
                     out_valid, out_sum, out_count, out_flags);
        end
        take();
    endtask

    task automatic test_reset_mid_frame();
        int c, cv;
        send(32'h3F800000, 1'b0, 1'b0, 1'b1, 3'b000, c);
        send(32'h40000000, 1'b0, 1'b0, 1'b0, 3'b000, c);
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({out_valid, in_ready, out_sum, out_count, out_flags, add_a, add_b} !== '0) begin
            n_err++;
            $display("FAIL midreset_outputs: valid=%0b ready=%0b sum=%h cnt=%h flg=%b a=%h b=%h required all 0",
                     out_valid, in_ready, out_sum, out_count, out_flags, add_a, add_b);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        send(32'h3F000000, 1'b0, 1'b1, 1'b1, 3'b000, c);
        wait_result(cv);
        n_cmp++;
        if ({out_sum, out_count} !== {32'h3F000000, 16'd1}) begin
            n_err++; $display("FAIL midreset_next: got %h/%0d required 3F000000/1", out_sum, out_count);
        end
        take();
    endtask

    task automatic test_flags();
        int c, cv;
        send(32'h3F800000, 1'b0, 1'b0, 1'b1, 3'b000, c);
        send(32'h40000000, 1'b0, 1'b0, 1'b0, 3'b000, c);
        send(32'h40400000, 1'b0, 1'b1, 1'b0, 3'b010, c);
        wait_result(cv);
        n_cmp++;
        if ({out_sum, out_count, out_flags} !== {32'h40C00000, 16'd3, 3'b010}) begin
            n_err++;
            $display("FAIL overflow_flag: got %h/%0d/%b required 40C00000/3/010", out_sum, out_count, out_flags);
        end
        take();
        send(32'h3F800000, 1'b0, 1'b0, 1'b1, 3'b000, c);
        send(32'h3F800000, 1'b0, 1'b1, 1'b0, 3'b100, c);
        wait_result(cv);
        n_cmp++;
        if ({out_sum, out_count, out_flags} !== {32'h40000000, 16'd2, 3'b100}) begin
            n_err++;
            $display("FAIL exception_flag: got %h/%0d/%b required 40000000/2/100", out_sum, out_count, out_flags);
        end
        take();
        send(32'h3F800000, 1'b0, 1'b1, 1'b1, 3'b000, c);
        wait_result(cv);
        n_cmp++;
        if (out_flags !== 3'b000) begin
            n_err++; $display("FAIL flags_clear: got %b required 000", out_flags);
        end
        take();
    endtask

    // Frame model: signed integer elements, sum in plain arithmetic, flags OR-ed.
    task automatic test_random();
        int c, cv, len, v, val, sum;
        logic neg, s;
        logic [2:0] f, flg;
        logic [31:0] exp_sum;
        for (int fr = 0; fr < 25; fr++) begin
            len = $urandom_range(1, 5);
            sum = 0;
            flg = 3'b000;
            for (int k = 0; k < len; k++) begin
                v   = $urandom_range(1, 100);
                neg = 1'($urandom_range(0, 1));
                s   = 1'($urandom_range(0, 1));
                val = (neg ^ s) ? -v : v;
                sum += val;
                f   = (k == 0) ? 3'b000 : 3'($urandom_range(0, 7));
                flg |= f;
                send(r2f(real'(neg ? -v : v)), s, (k == len - 1), (k == 0), f, c);
            end
            exp_q.push_back(r2f(real'(sum)));
            wait_result(cv);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            exp_sum = exp_q.pop_front();
            n_cmp++;
            if ({out_sum, out_count, out_flags} !== {exp_sum, 16'(len), flg}) begin
                n_err++;
                $display("FAIL random_frame%0d: got %h/%0d/%b required %h/%0d/%b",
                         fr, out_sum, out_count, out_flags, exp_sum, len, flg);
            end
            take();
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        rst = 1'b1;
        in_valid = 1'b0; in_data = '0; in_sub = 1'b0; in_last = 1'b0;
        out_ready = 1'b0;
        add_underflow = 1'b0; add_overflow = 1'b0; add_exception = 1'b0;
        test_reset();
        test_two_elem();
        test_single_sub();
        test_subtract();
        test_hold_and_same_cycle();
        test_reset_mid_frame();
        test_flags();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fp_accum_ctrl.md
FP_ACCUM_CTRL -- requirements
Module: fp_accum_ctrl

Interface
REQ-001 SHALL have one clock; reset is asynchronous and active-high.
REQ-002 SHALL provide: clk  in  1  rising-edge clock.
REQ-003 SHALL provide: rst  in  1  asynchronous active-high reset.
REQ-004 SHALL provide: in_valid  in  1  input element valid.
REQ-005 SHALL provide: in_ready  out  1  block accepts an element this cycle.
REQ-006 SHALL provide: in_data  in  32  IEEE-754 single-precision element.
REQ-007 SHALL provide: in_sub  in  1  element is subtracted (bit 31 inverted before use).
REQ-008 SHALL provide: in_last  in  1  element closes the frame.
REQ-009 SHALL provide: add_a  out  32  operand A to the external combinational adder/subtractor (running sum).
REQ-010 SHALL provide: add_b  out  32  operand B to the adder (registered element).
REQ-011 SHALL provide: add_res  in  32  adder result.
REQ-012 SHALL provide: add_underflow, add_overflow, add_exception  in  1 each  adder flags.
REQ-013 SHALL provide: out_valid  out  1  frame result valid.
REQ-014 SHALL provide: out_ready  in  1  consumer takes the result.
REQ-015 SHALL provide: out_sum  out  32  frame sum.
REQ-016 SHALL provide: out_count  out  16  elements in frame.
REQ-017 SHALL provide: out_flags  out  3  sticky {exception, overflow, underflow}.

Function
REQ-018 SHALL implement states IDLE, ACCUM, ADD, DONE.
REQ-019 SHALL use the accept condition in_valid & in_ready; in_ready = 1 in IDLE/ACCUM only.
REQ-020 IDLE accept: acc <= operand, bypassing the adder (the adder mishandles zero); count <= 1; flags <= 0; next state DONE if in_last, else ACCUM.
REQ-021 ACCUM accept: opb <= operand; count <= count+1, saturating at 16'hFFFF; last_q <= in_last; next state ADD.
REQ-022 ADD (one cycle, in_ready = 0): acc <= add_res; flags |= {add_exception, add_overflow, add_underflow}; next state DONE if last_q, else ACCUM.
REQ-023 DONE: out_valid = 1; out_sum/out_count/out_flags stable until out_ready; on out_ready, next state IDLE.
REQ-024 add_a = acc register and add_b = opb register, driven directly from flops; they change only on the edges defined above.
REQ-025 operand = {in_data[31] ^ in_sub, in_data[30:0]}; no other modification.
REQ-026 Throughput: one element per 2 cycles after the first; out_valid rises 1 cycle after the final accept (single-element frame) or 1 cycle after the final ADD.
REQ-027 in_valid in DONE or ADD SHALL be ignored, with no state change.
REQ-028 Out handshake and in_valid in the same DONE cycle SHALL NOT accept the element; it is accepted next cycle in IDLE.
REQ-029 ADD with add_exception set: acc takes add_res as delivered; the sticky flag records it; the frame continues.

Reset
REQ-030 On rst: state IDLE; acc, opb, count, flags, last_q = 0; in_ready = 0 while rst is asserted, then 1; out_valid = 0; add_a = add_b = 0.
REQ-031 Reset mid-frame SHALL abandon the frame with no output; the next accept starts a fresh frame with count 1.

Structure
REQ-032 Package fp_acc_pkg SHALL hold: the state enum; FP_W = 32; SIGN_BIT = 31; CNT_W = 16; flag indices FLG_EXC = 2, FLG_OVF = 1, FLG_UNF = 0.
REQ-033 The block SHALL have no sub-module; the adder/subtractor stays external and is wired in the parent.

Verification
REQ-034 Frame {3F800000, 40000000 last} -> out_sum 40400000, out_count 2, out_flags 0, out_valid 3 cycles after the first accept.
REQ-035 Frame {3FC00000 with in_sub, last} -> out_sum BFC00000, out_count 1; add_b stays unchanged throughout.
REQ-036 Frame {40400000, 3F800000 with in_sub, last} -> out_sum 40000000.
REQ-037 out_ready held 0 for 5 cycles in DONE -> out_valid, out_sum, out_count held; in_ready 0; in_valid pulses ignored.
REQ-038 rst after 2 accepts of a 4-element frame -> all outputs 0; the next frame {3F000000 last} gives out_sum 3F000000, out_count 1.
REQ-039 Bench forces add_overflow = 1 during the 2nd ADD of a 3-element frame -> out_flags = 3'b010; the flags clear on the next frame's first accept.
